// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers imem words into a valid/ready slot.
// Optional macro IMEM_FETCH_CNT_EN adds a saturating accepted-instruction counter (fetch_cnt).
module imem_fetch_ctrl #(
  parameter int unsigned   AW       = 8,
  parameter int unsigned   DW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [DW-1:0] HALT_OP  = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] imem_ad,
  input  logic [DW-1:0] imem_data,
  output logic [DW-1:0] ins,
  output logic [AW-1:0] ins_pc,
  output logic          ins_valid,
  input  logic          ins_ready,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
`ifdef IMEM_FETCH_CNT_EN
  output logic [15:0]   fetch_cnt,
`endif
  output logic          halted
);

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  localparam logic [AW-1:0] PcOne = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ins_q, ins_d;
  logic [AW-1:0] ins_pc_q, ins_pc_d;
  logic          ins_valid_q, ins_valid_d;
  logic          free;
  logic          is_halt_op;

  assign free       = !ins_valid_q || ins_ready;
  assign is_halt_op = (imem_data == HALT_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      ins_q       <= '0;
      ins_pc_q    <= '0;
      ins_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      ins_pc_q    <= ins_pc_d;
      ins_valid_q <= ins_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (redir_valid || start) state_d = StFetch;
      StFetch: if (!redir_valid && free && is_halt_op) state_d = StHalt;
      StHalt:  if (redir_valid) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  // Redirect beats capture; a stalled slot freezes PC so no address is skipped.
  always_comb begin
    pc_d        = pc_q;
    ins_d       = ins_q;
    ins_pc_d    = ins_pc_q;
    ins_valid_d = ins_valid_q;
    unique case (state_q)
      StIdle: begin
        if (redir_valid) pc_d = redir_pc;
      end
      StFetch: begin
        if (redir_valid) begin
          pc_d        = redir_pc;
          ins_valid_d = 1'b0;
        end else if (free) begin
          ins_d       = imem_data;
          ins_pc_d    = pc_q;
          ins_valid_d = 1'b1;
          if (!is_halt_op) pc_d = pc_q + PcOne;
        end
      end
      StHalt: begin
        if (redir_valid) begin
          pc_d        = redir_pc;
          ins_valid_d = 1'b0;
        end else if (ins_ready) begin
          ins_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    halted = (state_q == StHalt);
  end

  assign imem_ad   = pc_q;
  assign ins       = ins_q;
  assign ins_pc    = ins_pc_q;
  assign ins_valid = ins_valid_q;

`ifdef IMEM_FETCH_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (ins_valid_q && ins_ready && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_cnt_q <= '0;
    else     fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule
